// File: rtl/sha2_msg_sched.sv
// SHA-2 message-schedule engine: loads M[0..15] over a valid/ready stream, then expands
// W[16..ROUNDS-1]. Emits one word per cycle on a registered output stream.
module sha2_msg_sched #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [WORD_W-1:0] out_data,
  output logic [6:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_param_check
    $error("sha2_msg_sched: unsupported WORD_W/ROUNDS pair");
  end

  localparam int unsigned S0R1 = (WORD_W == 32) ? 7  : 1;
  localparam int unsigned S0R2 = (WORD_W == 32) ? 18 : 8;
  localparam int unsigned S0SH = (WORD_W == 32) ? 3  : 7;
  localparam int unsigned S1R1 = (WORD_W == 32) ? 17 : 19;
  localparam int unsigned S1R2 = (WORD_W == 32) ? 19 : 61;
  localparam int unsigned S1SH = (WORD_W == 32) ? 10 : 6;
  localparam logic [6:0]  LastT = 7'(ROUNDS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StExpand} state_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0R1) ^ rotr(x, S0R2) ^ (x >> S0SH);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1R1) ^ rotr(x, S1R2) ^ (x >> S1SH);
  endfunction

  state_e            state_q, state_d;
  logic [6:0]        t_q, t_d;
  // win_q[15] holds W[t-1], win_q[0] holds W[t-16]
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic              out_vld_q, out_vld_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [6:0]        out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;

  logic              adv, load_xfer, exp_xfer, xfer;
  logic [WORD_W-1:0] exp_word, new_word;

  always_comb begin
    adv       = !out_vld_q || out_rdy;
    load_xfer = (state_q == StLoad) && in_vld && adv;
    exp_xfer  = (state_q == StExpand) && adv;
    xfer      = !flush && (load_xfer || exp_xfer);
    exp_word  = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    new_word  = (state_q == StLoad) ? in_data : exp_word;

    state_d    = state_q;
    t_d        = t_q;
    win_d      = win_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;

    if (flush) begin
      state_d    = StIdle;
      t_d        = 7'd0;
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoad;
            t_d     = 7'd0;
          end
        end
        StLoad: begin
          if (load_xfer) begin
            t_d = t_q + 7'd1;
            if (t_q == 7'd15) state_d = StExpand;
          end
        end
        StExpand: begin
          if (exp_xfer) begin
            if (t_q == LastT) begin
              state_d = StIdle;
              t_d     = 7'd0;
            end else begin
              t_d = t_q + 7'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (xfer) begin
        for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
        win_d[15]  = new_word;
        out_vld_d  = 1'b1;
        out_data_d = new_word;
        out_idx_d  = t_q;
        out_last_d = exp_xfer && (t_q == LastT);
      end else if (out_rdy) begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      t_q        <= 7'd0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= 7'd0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      win_q      <= win_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
    end
  end

  always_comb begin
    in_rdy   = (state_q == StLoad) && adv;
    out_vld  = out_vld_q;
    out_data = out_data_q;
    out_idx  = out_idx_q;
    out_last = out_last_q;
    busy     = (state_q != StIdle) || out_vld_q;
  end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Scoreboard bench for sha2_msg_sched: a 32-bit and a 64-bit instance, expected schedules from a
// direct recurrence model, checked by negedge monitors decoupled from the stimulus.
module tb_sha2_msg_sched;

  logic        clk, reset_n;
  logic        start, flush, in_vld, in_rdy, out_vld, out_rdy, out_last, busy;
  logic [31:0] in_data, out_data;
  logic [6:0]  out_idx;

  logic        start64, flush64, in_vld64, in_rdy64, out_vld64, out_rdy64, out_last64, busy64;
  logic [63:0] in_data64, out_data64;
  logic [6:0]  out_idx64;

  sha2_msg_sched #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .in_vld(in_vld),
    .in_rdy(in_rdy), .in_data(in_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  sha2_msg_sched #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .start(start64), .flush(flush64), .in_vld(in_vld64),
    .in_rdy(in_rdy64), .in_data(in_data64), .out_vld(out_vld64), .out_rdy(out_rdy64),
    .out_data(out_data64), .out_idx(out_idx64), .out_last(out_last64), .busy(busy64)
  );

  typedef struct {
    logic [63:0] data;
    int          idx;
    logic        last;
  } exp_t;

  exp_t        q32[$];
  exp_t        q64[$];
  int          first_cycs[$];
  int          last_cycs[$];
  logic [63:0] msg   [16];
  logic [63:0] ref_w [80];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          rand_rdy = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    out_rdy = 1;
    forever begin
      @(posedge clk);
      #1 out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=expired required=event", name);
  endtask

  // Reference: the SHA-2 recurrence evaluated directly over a flat array.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    return (((x & m) >> n) | ((x & m) << (w - n))) & m;
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
    return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
    return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  function automatic void build_ref(input int w, input int rounds);
    logic [63:0] m;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < rounds; t++) begin
      if (t < 16) ref_w[t] = msg[t] & m;
      else ref_w[t] = (sig1(ref_w[t-2], w) + ref_w[t-7] + sig0(ref_w[t-15], w) + ref_w[t-16]) & m;
    end
  endfunction

  // 32-bit monitor: scoreboard pop on every taken word, plus hold-stability while stalled.
  logic        stall = 0;
  logic [31:0] hd;
  logic [6:0]  hi;
  logic        hl;
  exp_t        e32, e64;

  always @(negedge clk) begin
    if (!reset_n || flush) begin
      q32.delete();
      stall = 0;
    end else begin
      if (stall) begin
        check("hold_vld", out_vld, 1);
        check("hold_data", out_data, hd);
        check("hold_idx", out_idx, hi);
        check("hold_last", out_last, hl);
      end
      if (out_vld && out_rdy) begin
        if (q32.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_w32 actual=idx%0d required=no_output", out_idx);
        end else begin
          e32 = q32.pop_front();
          check($sformatf("w32[%0d]_data", e32.idx), out_data, e32.data);
          check($sformatf("w32[%0d]_idx", e32.idx), out_idx, e32.idx);
          check($sformatf("w32[%0d]_last", e32.idx), out_last, e32.last);
          if (e32.idx == 0) first_cycs.push_back(cyc);
          if (e32.last) last_cycs.push_back(cyc);
        end
        stall = 0;
      end else if (out_vld) begin
        stall = 1;
        hd = out_data;
        hi = out_idx;
        hl = out_last;
      end else begin
        stall = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      q64.delete();
    end else if (out_vld64 && out_rdy64) begin
      if (q64.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_w64 actual=idx%0d required=no_output", out_idx64);
      end else begin
        e64 = q64.pop_front();
        check($sformatf("w64[%0d]_data", e64.idx), out_data64, e64.data);
        check($sformatf("w64[%0d]_idx", e64.idx), out_idx64, e64.idx);
        check($sformatf("w64[%0d]_last", e64.idx), out_last64, e64.last);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!busy || (out_vld && out_last && out_rdy)) break;
      n++;
      if (n > 5000) begin
        fail_timeout("wait_idle");
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (q32.size() == 0 && !busy) break;
      n++;
      if (n > 5000) begin
        fail_timeout("wait_drain");
        break;
      end
    end
    check("drain_queue_empty", 64'(q32.size()), 0);
  endtask

  // Loads msg[0..15] into the 32-bit engine; with gaps, in_vld stutters and start is spammed.
  task automatic send_block(input bit gaps);
    int n;
    bit acc;
    wait_idle();
    build_ref(32, 64);
    for (int t = 0; t < 64; t++) q32.push_back('{ref_w[t], t, (t == 63)});
    start = 1;
    @(posedge clk);
    #2;
    start = 0;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      forever begin
        in_data = msg[i][31:0];
        in_vld  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        start   = gaps && ($urandom_range(0, 3) == 0);
        @(negedge clk);
        acc = in_vld && in_rdy;
        @(posedge clk);
        #2;
        if (acc) break;
        n++;
        if (n > 200) begin
          fail_timeout("load_word");
          in_vld = 0;
          start  = 0;
          return;
        end
      end
    end
    in_vld = 0;
    start  = 0;
    if (gaps) begin
      repeat (4) begin
        start = 1;
        @(posedge clk);
        #2;
      end
      start = 0;
    end
  endtask

  task automatic set_abc32();
    for (int i = 0; i < 16; i++) msg[i] = 64'h0;
    msg[0]  = 64'h6162_6380;
    msg[15] = 64'h18;
  endtask

  task automatic set_rand32();
    for (int i = 0; i < 16; i++) msg[i] = {32'h0, $urandom};
  endtask

  task automatic drive64();
    int n;
    bit acc;
    for (int i = 0; i < 16; i++) msg[i] = 64'h0;
    msg[0]  = 64'h6162_6380_0000_0000;
    msg[15] = 64'h18;
    build_ref(64, 80);
    for (int t = 0; t < 80; t++) q64.push_back('{ref_w[t], t, (t == 79)});
    @(posedge clk);
    #2;
    start64 = 1;
    @(posedge clk);
    #2;
    start64 = 0;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      forever begin
        in_vld64  = 1;
        in_data64 = msg[i];
        @(negedge clk);
        acc = in_rdy64;
        @(posedge clk);
        #2;
        if (acc) break;
        n++;
        if (n > 200) begin
          fail_timeout("load_word64");
          break;
        end
      end
    end
    in_vld64 = 0;
    n = 0;
    while (q64.size() != 0 || busy64) begin
      @(posedge clk);
      #2;
      n++;
      if (n > 1000) begin
        fail_timeout("drain64");
        break;
      end
    end
    check("drain64_queue_empty", 64'(q64.size()), 0);
  endtask

  initial begin
    int n;
    reset_n   = 0;
    start     = 0;
    flush     = 0;
    in_vld    = 0;
    in_data   = '0;
    start64   = 0;
    flush64   = 0;
    in_vld64  = 0;
    in_data64 = '0;
    out_rdy64 = 1;

    #12;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_vld64", out_vld64, 0);
    check("rst_busy64", busy64, 0);
    @(posedge clk);
    #2 reset_n = 1;

    // "abc" block, full-rate consumer
    set_abc32();
    send_block(0);
    wait_drain();

    // 64-bit variant
    drive64();

    // Random backpressure and input gaps
    rand_rdy = 1;
    set_abc32();
    send_block(1);
    wait_drain();
    set_rand32();
    send_block(1);
    wait_drain();

    // Flush while W[30] is presented, then a fresh block
    set_rand32();
    send_block(1);
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (out_vld && out_idx == 7'd30) break;
      n++;
      if (n > 2000) begin
        fail_timeout("idx30");
        break;
      end
    end
    flush = 1;
    @(posedge clk);
    #2;
    flush = 0;
    check("flush_out_vld", out_vld, 0);
    check("flush_out_last", out_last, 0);
    check("flush_busy", busy, 0);
    set_rand32();
    send_block(0);
    wait_drain();

    // Back-to-back blocks, second start on the out_last drain cycle
    rand_rdy = 0;
    @(posedge clk);
    #2;
    first_cycs.delete();
    last_cycs.delete();
    set_rand32();
    send_block(0);
    set_rand32();
    send_block(0);
    wait_drain();
    check("b2b_first_count", 64'(first_cycs.size()), 2);
    check("b2b_last_count", 64'(last_cycs.size()), 2);
    if (first_cycs.size() >= 2 && last_cycs.size() >= 2) begin
      check("b2b_block1_span", 64'(last_cycs[0] - first_cycs[0]), 63);
      check("b2b_gap", 64'(first_cycs[1] - last_cycs[0]), 2);
      check("b2b_block2_span", 64'(last_cycs[1] - first_cycs[1]), 63);
    end

    // Asynchronous reset mid-EXPAND
    rand_rdy = 1;
    set_rand32();
    send_block(0);
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (out_vld && out_idx >= 7'd20) break;
      n++;
      if (n > 2000) begin
        fail_timeout("idx20");
        break;
      end
    end
    #1 reset_n = 0;
    #1;
    check("arst_in_rdy", in_rdy, 0);
    check("arst_out_vld", out_vld, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_idx", out_idx, 0);
    check("arst_out_last", out_last, 0);
    check("arst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1;
    set_rand32();
    send_block(1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
